// File: rtl/silu_stage_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | silu_stage_ctrl_pkg : shared types and widths for the SILU stage ctrl |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package silu_stage_ctrl_pkg;

  localparam int IN_W         = 64;
  localparam int OUT_W        = 128;
  localparam int DATA_NUM_DEF = 192;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/silu_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | silu_stage_ctrl : streams one stage of beats through SILU and writes  |
// | the results back, with credit-limited issue and a result timeout.     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module silu_stage_ctrl
  import silu_stage_ctrl_pkg::*;
#(
  parameter int DATA_NUM     = DATA_NUM_DEF,
  parameter int ADDR_W       = 8,
  parameter int MAX_INFLIGHT = 16,
  parameter int TIMEOUT      = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_start,
  input  logic              i_cmd_abort,
  input  logic [ADDR_W-1:0] i_cmd_src_base,
  input  logic [ADDR_W-1:0] i_cmd_dst_base,
  output logic              o_cmd_busy,
  output logic              o_cmd_done,
  output logic              o_cmd_err,
  output logic              o_src_rd_en,
  output logic [ADDR_W-1:0] o_src_rd_addr,
  input  logic [IN_W-1:0]   i_src_rd_data,
  output logic              o_silu_stage_start,
  output logic              o_silu_a_tvalid,
  output logic [IN_W-1:0]   o_silu_a_tdata,
  input  logic              i_silu_result_tvalid,
  input  logic [OUT_W-1:0]  i_silu_result_tdata,
  output logic              o_dst_wr_en,
  output logic [ADDR_W-1:0] o_dst_wr_addr,
  output logic [OUT_W-1:0]  o_dst_wr_data
);

  localparam int CNT_W = $clog2(DATA_NUM + 1);
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);
  localparam int TO_W  = $clog2(TIMEOUT);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_recv_cnt;
  logic [INF_W-1:0]   r_inflight;
  logic [TO_W-1:0]    r_to_cnt;
  logic [ADDR_W-1:0]  r_src_base;
  logic [ADDR_W-1:0]  r_dst_base;
  logic               r_a_tvalid;
  logic               r_dst_wr_en;
  logic [ADDR_W-1:0]  r_dst_wr_addr;
  logic [OUT_W-1:0]   r_dst_wr_data;

  logic w_active;
  logic w_start_acc;
  logic w_rd_en;
  logic w_res_cnt;
  logic w_timeout;

  assign w_active    = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign w_start_acc = (r_state == ST_IDLE) && i_cmd_start && !i_cmd_abort;
  assign w_rd_en     = (r_state == ST_ISSUE) && !i_cmd_abort &&
                       (r_issue_cnt < CNT_W'(DATA_NUM)) &&
                       (r_inflight < INF_W'(MAX_INFLIGHT));
  // A result with no outstanding credit is stray and must not be counted.
  assign w_res_cnt   = w_active && !i_cmd_abort && i_silu_result_tvalid &&
                       (r_inflight != '0);
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT - 1)) && !w_res_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_cmd_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_cmd_start) w_next = ST_ARM;
        ST_ARM:   w_next = ST_ISSUE;
        ST_ISSUE: begin
          if (w_timeout)                             w_next = ST_ERR;
          else if (r_issue_cnt == CNT_W'(DATA_NUM))  w_next = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_recv_cnt == CNT_W'(DATA_NUM)) w_next = ST_DONE;
          else if (w_timeout)                 w_next = ST_ERR;
        end
        ST_DONE:  w_next = ST_IDLE;
        ST_ERR:   w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_cmd_busy         = (r_state != ST_IDLE);
    o_cmd_done         = (r_state == ST_DONE) || (r_state == ST_ERR);
    o_cmd_err          = (r_state == ST_ERR);
    o_silu_stage_start = (r_state == ST_ARM) || w_active;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_cnt   <= '0;
      r_recv_cnt    <= '0;
      r_inflight    <= '0;
      r_to_cnt      <= '0;
      r_src_base    <= '0;
      r_dst_base    <= '0;
      r_a_tvalid    <= 1'b0;
      r_dst_wr_en   <= 1'b0;
      r_dst_wr_addr <= '0;
      r_dst_wr_data <= '0;
    end else begin
      if (w_start_acc) begin
        r_src_base  <= i_cmd_src_base;
        r_dst_base  <= i_cmd_dst_base;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
        r_inflight  <= '0;
        r_to_cnt    <= '0;
      end else begin
        if (w_rd_en)   r_issue_cnt <= r_issue_cnt + 1'b1;
        if (w_res_cnt) r_recv_cnt  <= r_recv_cnt + 1'b1;
        case ({w_rd_en, w_res_cnt})
          2'b10:   r_inflight <= r_inflight + 1'b1;
          2'b01:   r_inflight <= r_inflight - 1'b1;
          default: r_inflight <= r_inflight;
        endcase
        if ((r_state == ST_ARM) || w_res_cnt) r_to_cnt <= '0;
        else if (w_active)                    r_to_cnt <= r_to_cnt + 1'b1;
      end
      r_a_tvalid    <= w_rd_en;
      r_dst_wr_en   <= w_res_cnt;
      r_dst_wr_addr <= w_res_cnt ? ADDR_W'(r_dst_base + ADDR_W'(r_recv_cnt)) : '0;
      r_dst_wr_data <= w_res_cnt ? i_silu_result_tdata : '0;
    end
  end

  assign o_src_rd_en   = w_rd_en;
  assign o_src_rd_addr = w_rd_en ? ADDR_W'(r_src_base + ADDR_W'(r_issue_cnt)) : '0;

  // Read data already in flight when an abort lands is dropped here.
  assign o_silu_a_tvalid = r_a_tvalid && !i_cmd_abort;
  assign o_silu_a_tdata  = o_silu_a_tvalid ? i_src_rd_data : '0;

  assign o_dst_wr_en   = r_dst_wr_en;
  assign o_dst_wr_addr = r_dst_wr_addr;
  assign o_dst_wr_data = r_dst_wr_data;

endmodule
`default_nettype wire
